// File: rtl/spi_init_sequencer_pkg.sv
// Shared definitions for the SPI init sequencer: table entry layout, op codes,
// FSM state encoding and default sizing.
package spi_init_sequencer_pkg;

    localparam int DEFAULT_TABLE_DEPTH = 32;
    localparam int DEFAULT_ACK_TIMEOUT = 16;

    localparam int ENTRY_W  = 25;
    localparam int OP_MSB   = 24;
    localparam int OP_LSB   = 23;
    localparam int ADDR_MSB = 22;
    localparam int ADDR_LSB = 12;
    localparam int DATA_MSB = 11;
    localparam int DATA_LSB = 0;

    typedef enum logic [1:0] {
        OP_DAC_WR    = 2'd0,
        OP_ADC_WR    = 2'd1,
        OP_ADC_RDCHK = 2'd2,
        OP_END       = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_CHECK     = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERROR     = 3'd7
    } seq_state_t;

    function automatic logic [ENTRY_W-1:0] make_entry(input op_t op, input logic [10:0] addr,
                                                      input logic [11:0] data);
        return {op, addr, data};
    endfunction

    // Entry 0 is END, so an un-customised table finishes immediately.
    localparam logic [DEFAULT_TABLE_DEPTH*ENTRY_W-1:0] DEFAULT_INIT_TABLE =
        {{((DEFAULT_TABLE_DEPTH - 1) * ENTRY_W){1'b0}}, OP_END, 23'd0};

endpackage

// File: rtl/spi_init_sequencer_if.sv
// Sequencer <-> SPI controller link. A request strobe is a one-cycle pulse issued only
// while spi_busy = 0; the controller acknowledges by raising spi_busy and finishes by dropping it.
interface spi_init_sequencer_if;

    logic        dac_request_write;
    logic [4:0]  dac_address;
    logic [11:0] dac_data;
    logic        adc_request_write;
    logic        adc_request_read;
    logic [10:0] adc_address;
    logic [7:0]  adc_data;
    logic [7:0]  adc_data_readback;
    logic        spi_busy;

    modport master (
        output dac_request_write, dac_address, dac_data,
        output adc_request_write, adc_request_read, adc_address, adc_data,
        input  adc_data_readback, spi_busy
    );

    modport slave (
        input  dac_request_write, dac_address, dac_data,
        input  adc_request_write, adc_request_read, adc_address, adc_data,
        output adc_data_readback, spi_busy
    );

endinterface

// File: rtl/spi_init_rom.sv
// Synchronous init-table ROM, one-cycle read latency; contents come from a packed parameter
// with entry 0 in the least-significant bits.
module spi_init_rom
    import spi_init_sequencer_pkg::*;
#(
    parameter int TABLE_DEPTH = DEFAULT_TABLE_DEPTH,
    parameter logic [TABLE_DEPTH*ENTRY_W-1:0] INIT_TABLE = DEFAULT_INIT_TABLE
) (
    input  logic               sys_clk,
    input  logic [4:0]         addr,
    output logic [ENTRY_W-1:0] data
);

    always_ff @(posedge sys_clk) begin
        if (int'(addr) < TABLE_DEPTH) begin
            data <= INIT_TABLE[int'(addr)*ENTRY_W +: ENTRY_W];
        end else begin
            data <= {OP_END, 23'd0};
        end
    end

endmodule

// File: rtl/spi_init_sequencer.sv
// Walks the init table and replays each entry as a DAC write, ADC write or ADC
// read-and-compare through the SPI controller, flagging timeouts and readback mismatches.
module spi_init_sequencer
    import spi_init_sequencer_pkg::*;
#(
    parameter int TABLE_DEPTH = DEFAULT_TABLE_DEPTH,
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
    parameter bit AUTO_START  = 1'b1,
    parameter logic [TABLE_DEPTH*ENTRY_W-1:0] INIT_TABLE = DEFAULT_INIT_TABLE
) (
    input  logic                        sys_clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        seq_busy,
    output logic                        seq_done,
    output logic                        seq_error,
    output logic [7:0]                  mismatch_count,
    output seq_state_t                  debug_state,
    spi_init_sequencer_if.master        spi
);

    localparam int IDX_W = $clog2(TABLE_DEPTH + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    seq_state_t         state, state_d;
    logic [IDX_W-1:0]   index, index_d;
    logic [TMO_W-1:0]   timer, timer_d;
    logic               auto_pending;
    op_t                entry_op;
    logic [7:0]         entry_expect;
    logic [ENTRY_W-1:0] rom_data;
    op_t                rom_op;

    logic        run_start, load_entry, err_set, mismatch;
    logic        dac_wr_stb, adc_wr_stb, adc_rd_stb;
    logic [4:0]  dac_address_q;
    logic [11:0] dac_data_q;
    logic [10:0] adc_address_q;
    logic [7:0]  adc_data_q;

    // The ROM is addressed with the next index so its registered output already
    // holds the current entry during the FETCH cycle.
    spi_init_rom #(
        .TABLE_DEPTH (TABLE_DEPTH),
        .INIT_TABLE  (INIT_TABLE)
    ) u_rom (
        .sys_clk (sys_clk),
        .addr    (5'(index_d)),
        .data    (rom_data)
    );

    assign rom_op = op_t'(rom_data[OP_MSB:OP_LSB]);

    always_comb begin
        state_d    = state;
        index_d    = index;
        timer_d    = timer;
        run_start  = 1'b0;
        load_entry = 1'b0;
        err_set    = 1'b0;
        mismatch   = 1'b0;
        dac_wr_stb = 1'b0;
        adc_wr_stb = 1'b0;
        adc_rd_stb = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start || auto_pending) begin
                    run_start = 1'b1;
                    index_d   = '0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (index == IDX_W'(TABLE_DEPTH) || rom_op == OP_END) begin
                    state_d = ST_DONE;
                end else begin
                    load_entry = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!spi.spi_busy) begin
                    timer_d = '0;
                    state_d = ST_WAIT_ACK;
                    case (entry_op)
                        OP_DAC_WR:    dac_wr_stb = 1'b1;
                        OP_ADC_WR:    adc_wr_stb = 1'b1;
                        OP_ADC_RDCHK: adc_rd_stb = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_WAIT_ACK: begin
                if (spi.spi_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer == TMO_W'(ACK_TIMEOUT - 1)) begin
                    err_set = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!spi.spi_busy) begin
                    if (entry_op == OP_ADC_RDCHK) begin
                        state_d = ST_CHECK;
                    end else begin
                        index_d = index + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_CHECK: begin
                if (spi.adc_data_readback != entry_expect) begin
                    err_set  = 1'b1;
                    mismatch = 1'b1;
                end
                index_d = index + 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            index          <= '0;
            timer          <= '0;
            auto_pending   <= AUTO_START;
            entry_op       <= OP_DAC_WR;
            entry_expect   <= '0;
            seq_error      <= 1'b0;
            mismatch_count <= '0;
            dac_address_q  <= '0;
            dac_data_q     <= '0;
            adc_address_q  <= '0;
            adc_data_q     <= '0;
        end else begin
            state <= state_d;
            index <= index_d;
            timer <= timer_d;
            if (run_start) begin
                auto_pending   <= 1'b0;
                seq_error      <= 1'b0;
                mismatch_count <= '0;
            end else begin
                if (err_set) seq_error <= 1'b1;
                if (mismatch && mismatch_count != 8'hFF) mismatch_count <= mismatch_count + 8'd1;
            end
            // Address/data registers only change on entry load, so they stay put until the next FETCH.
            if (load_entry) begin
                entry_op     <= rom_op;
                entry_expect <= rom_data[DATA_LSB+7:DATA_LSB];
                if (rom_op == OP_DAC_WR) begin
                    dac_address_q <= rom_data[ADDR_LSB+4:ADDR_LSB];
                    dac_data_q    <= rom_data[DATA_MSB:DATA_LSB];
                end else begin
                    adc_address_q <= rom_data[ADDR_MSB:ADDR_LSB];
                    if (rom_op == OP_ADC_WR) adc_data_q <= rom_data[DATA_LSB+7:DATA_LSB];
                end
            end
        end
    end

    assign seq_busy    = !(state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    assign seq_done    = (state == ST_DONE);
    assign debug_state = state;

    assign spi.dac_request_write = dac_wr_stb;
    assign spi.adc_request_write = adc_wr_stb;
    assign spi.adc_request_read  = adc_rd_stb;
    assign spi.dac_address       = dac_address_q;
    assign spi.dac_data          = dac_data_q;
    assign spi.adc_address       = adc_address_q;
    assign spi.adc_data          = adc_data_q;

endmodule

// File: tb/tb_spi_init_sequencer.sv
// Bench for spi_init_sequencer: SPI controller model, request scoreboard, table of
// whole-run vectors plus hand-written busy-hold and mid-transfer reset sequences.
module tb_spi_init_sequencer;
  import spi_init_sequencer_pkg::*;

  localparam logic [32*ENTRY_W-1:0] TB_TABLE = {
    {(27 * ENTRY_W){1'b0}},
    make_entry(OP_END,       11'h000, 12'h000),
    make_entry(OP_ADC_WR,    11'h101, 12'h080),
    make_entry(OP_ADC_RDCHK, 11'h2A5, 12'h05C),
    make_entry(OP_ADC_RDCHK, 11'h2A5, 12'h05C),
    make_entry(OP_DAC_WR,    11'h013, 12'hABC)
  };

  localparam logic [24:0] EXP_DAC = {2'd0, 11'h013, 12'hABC};
  localparam logic [24:0] EXP_RD  = {2'd2, 11'h2A5, 12'h000};
  localparam logic [24:0] EXP_WR  = {2'd1, 11'h101, 12'h080};

  typedef struct {
    bit          via_reset;
    bit          dead;
    int          busy_len;
    logic [7:0]  rb0;
    logic [7:0]  rb1;
    logic        exp_done;
    logic        exp_err;
    logic [7:0]  exp_mm;
    seq_state_t  exp_state;
  } run_vec_t;

  logic       sys_clk, reset, start;
  logic       seq_busy, seq_done, seq_error;
  logic [7:0] mismatch_count;
  seq_state_t debug_state;

  spi_init_sequencer_if spi_if();

  spi_init_sequencer #(
    .INIT_TABLE (TB_TABLE)
  ) dut (
    .sys_clk        (sys_clk),
    .reset          (reset),
    .start          (start),
    .seq_busy       (seq_busy),
    .seq_done       (seq_done),
    .seq_error      (seq_error),
    .mismatch_count (mismatch_count),
    .debug_state    (debug_state),
    .spi            (spi_if)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---------------- SPI controller model ----------------
  logic       model_busy, hold_busy, dead_mode;
  logic [7:0] model_rb;
  int         busy_cnt, busy_len;
  logic [7:0] rb_q[$];
  logic       any_req;

  assign any_req = spi_if.dac_request_write | spi_if.adc_request_write | spi_if.adc_request_read;
  assign spi_if.spi_busy = model_busy | hold_busy;
  assign spi_if.adc_data_readback = model_rb;

  always @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      model_busy <= 1'b0;
      busy_cnt   <= 0;
      model_rb   <= 8'h00;
    end else begin
      if (model_busy) begin
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) model_busy <= 1'b0;
      end else if (any_req && !dead_mode) begin
        model_busy <= 1'b1;
        busy_cnt   <= (busy_len == 0) ? int'($urandom_range(10, 2)) : busy_len;
      end
      if (spi_if.adc_request_read && rb_q.size() != 0) model_rb <= rb_q.pop_front();
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [24:0] exp_q[$];
  logic [24:0] last_word = '0;
  logic [24:0] exp_word;
  logic [1:0]  last_kind = 2'd0;
  int          strobe_count = 0;
  int          last_strobe_cyc = 0;
  int          nstb;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] req_word(input logic [1:0] kind);
    case (kind)
      2'd0:    return {2'd0, 6'd0, spi_if.dac_address, spi_if.dac_data};
      2'd1:    return {2'd1, spi_if.adc_address, 4'd0, spi_if.adc_data};
      default: return {2'd2, spi_if.adc_address, 12'd0};
    endcase
  endfunction

  always @(negedge sys_clk) begin
    if (!reset) begin
      nstb = int'(spi_if.dac_request_write) + int'(spi_if.adc_request_write)
           + int'(spi_if.adc_request_read);
      if (nstb != 0) begin
        checks++;
        if (nstb != 1 || spi_if.spi_busy) begin
          errors++;
          $display("FAIL strobe_rules strobes=%0d spi_busy=%0b required one strobe with spi_busy=0",
                   nstb, spi_if.spi_busy);
        end
        last_kind = spi_if.adc_request_read ? 2'd2 : (spi_if.adc_request_write ? 2'd1 : 2'd0);
        last_word = req_word(last_kind);
        strobe_count++;
        last_strobe_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_request actual=0x%0h required none", last_word);
        end else begin
          exp_word = exp_q.pop_front();
          check_val("request", 32'(last_word), 32'(exp_word));
        end
      end
      if (debug_state == ST_WAIT_DONE && !spi_if.spi_busy)
        check_val("hold_stable", 32'(req_word(last_kind)), 32'(last_word));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge sys_clk) start = 1'b1;
    @(negedge sys_clk) start = 1'b0;
  endtask

  task automatic push_run(input bit dead, input logic [7:0] rb0, input logic [7:0] rb1);
    exp_q.push_back(EXP_DAC);
    if (!dead) begin
      exp_q.push_back(EXP_RD);
      exp_q.push_back(EXP_RD);
      exp_q.push_back(EXP_WR);
      rb_q.push_back(rb0);
      rb_q.push_back(rb1);
    end
  endtask

  task automatic wait_run_end(input int budget, output bit ok);
    int  n;
    bit  rose;
    n = 0;
    while (!seq_busy && n < 4) begin
      @(negedge sys_clk);
      n++;
    end
    rose = seq_busy;
    n = 0;
    while (seq_busy && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    ok = rose && !seq_busy;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_seq_busy"}, 32'(seq_busy), 32'd0);
    check_val({tag, "_seq_done"}, 32'(seq_done), 32'd0);
    check_val({tag, "_seq_error"}, 32'(seq_error), 32'd0);
    check_val({tag, "_mismatch_count"}, 32'(mismatch_count), 32'd0);
    check_val({tag, "_state"}, 32'(debug_state), 32'(ST_IDLE));
    check_val({tag, "_strobes"}, 32'({spi_if.dac_request_write, spi_if.adc_request_write,
                                      spi_if.adc_request_read}), 32'd0);
    check_val({tag, "_dac_address"}, 32'(spi_if.dac_address), 32'd0);
    check_val({tag, "_dac_data"}, 32'(spi_if.dac_data), 32'd0);
    check_val({tag, "_adc_address"}, 32'(spi_if.adc_address), 32'd0);
    check_val({tag, "_adc_data"}, 32'(spi_if.adc_data), 32'd0);
  endtask

  task automatic run_vector(input int idx, input run_vec_t v);
    bit ok;
    int stb_before;
    busy_len  = v.busy_len;
    dead_mode = v.dead;
    push_run(v.dead, v.rb0, v.rb1);
    if (v.via_reset) begin
      reset = 1'b1;
      @(negedge sys_clk) reset = 1'b0;
    end else begin
      pulse_start();
    end
    wait_run_end(3000, ok);
    check_val($sformatf("v%0d_run_end", idx), 32'(ok), 32'd1);
    check_val($sformatf("v%0d_seq_done", idx), 32'(seq_done), 32'(v.exp_done));
    check_val($sformatf("v%0d_seq_error", idx), 32'(seq_error), 32'(v.exp_err));
    check_val($sformatf("v%0d_mismatch_count", idx), 32'(mismatch_count), 32'(v.exp_mm));
    check_val($sformatf("v%0d_state", idx), 32'(debug_state), 32'(v.exp_state));
    check_val($sformatf("v%0d_requests_left", idx), 32'(exp_q.size()), 32'd0);
    if (v.dead) begin
      check_val($sformatf("v%0d_timeout_cycles", idx), 32'(cyc - last_strobe_cyc),
                32'(DEFAULT_ACK_TIMEOUT + 1));
      stb_before = strobe_count;
      repeat (20) @(negedge sys_clk);
      check_val($sformatf("v%0d_no_strobe_after_error", idx), 32'(strobe_count), 32'(stb_before));
      check_val($sformatf("v%0d_error_holds", idx), 32'(debug_state), 32'(ST_ERROR));
    end
    exp_q.delete();
    rb_q.delete();
  endtask

  // ---------------- test ----------------
  run_vec_t vecs[5];

  initial begin
    bit ok;
    int stb0;
    vecs[0] = '{1'b1, 1'b0, 40, 8'h5C, 8'h5C, 1'b1, 1'b0, 8'd0, ST_DONE};
    vecs[1] = '{1'b0, 1'b0, 0,  8'h5C, 8'h5D, 1'b1, 1'b1, 8'd1, ST_DONE};
    vecs[2] = '{1'b0, 1'b0, 0,  8'h5D, 8'h00, 1'b1, 1'b1, 8'd2, ST_DONE};
    vecs[3] = '{1'b0, 1'b1, 0,  8'h00, 8'h00, 1'b0, 1'b1, 8'd0, ST_ERROR};
    vecs[4] = '{1'b0, 1'b0, 5,  8'h5C, 8'h5C, 1'b1, 1'b0, 8'd0, ST_DONE};

    reset = 1'b1;
    start = 1'b0;
    hold_busy = 1'b0;
    dead_mode = 1'b0;
    busy_len = 4;
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");

    for (int i = 0; i < 5; i++) run_vector(i, vecs[i]);

    // Controller already busy when ISSUE is reached; start during the run must be ignored.
    dead_mode = 1'b0;
    busy_len  = 0;
    hold_busy = 1'b1;
    push_run(1'b0, 8'h5C, 8'h5C);
    pulse_start();
    stb0 = strobe_count;
    repeat (6) @(negedge sys_clk);
    pulse_start();
    repeat (4) @(negedge sys_clk);
    check_val("hold_state", 32'(debug_state), 32'(ST_ISSUE));
    check_val("hold_no_strobe", 32'(strobe_count), 32'(stb0));
    hold_busy = 1'b0;
    wait_run_end(3000, ok);
    check_val("hold_run_end", 32'(ok), 32'd1);
    check_val("hold_seq_done", 32'(seq_done), 32'd1);
    check_val("hold_strobe_total", 32'(strobe_count - stb0), 32'd4);
    check_val("hold_requests_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rb_q.delete();

    // Reset pulsed while a transfer is in WAIT_DONE, then auto-start from index 0.
    busy_len = 40;
    push_run(1'b0, 8'h5C, 8'h5C);
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (debug_state == ST_WAIT_DONE) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("reach_wait_done", 32'(ok), 32'd1);
    #3 reset = 1'b1;
    #1 check_all_zero("midreset");
    exp_q.delete();
    rb_q.delete();
    stb0 = strobe_count;
    repeat (3) @(negedge sys_clk);
    check_val("midreset_no_strobe", 32'(strobe_count), 32'(stb0));
    busy_len = 0;
    push_run(1'b0, 8'h5C, 8'h5C);
    reset = 1'b0;
    wait_run_end(3000, ok);
    check_val("restart_run_end", 32'(ok), 32'd1);
    check_val("restart_seq_done", 32'(seq_done), 32'd1);
    check_val("restart_seq_error", 32'(seq_error), 32'd0);
    check_val("restart_requests_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
